// File: rtl/multicycle_control_unit.sv
// Multi-cycle control unit for the 16-bit processor: FETCH/DECODE/EXEC/MEM/WB sequencing,
// Moore control strobes, memory-ready stalls, retired-instruction count and sticky illegal-opcode flag.
// Optional build macro HALT_OPCODE_EN turns the all-ones opcode into a HALT that parks in state 5.
//
// state  | meaning
// FETCH  | read instruction memory; load IR and PC when mem_ready
// DECODE | latch opcode into op_q, flag illegal opcodes
// EXEC   | ALU step; jump/branch retire here
// MEM    | data memory access for lw/sw; held until mem_ready
// WB     | register file writeback for R-type/lw
// HALT   | parked with all strobes low until reset (HALT_OPCODE_EN only)

module multicycle_control_unit #(
  parameter int OPCODE_W = 4,
  parameter int ALUOP_W  = 2,
  parameter int CNT_W    = 16
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                ir_write,
  output logic                reg_dst,
  output logic                alu_src,
  output logic                mem_to_reg,
  output logic                reg_write,
  output logic                mem_read,
  output logic                mem_write,
  output logic                branch,
  output logic                jump,
  output logic [ALUOP_W-1:0]  alu_op,
  output logic [2:0]          state,
  output logic                illegal_op,
  output logic [CNT_W-1:0]    retired
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [OPCODE_W-1:0] OP_JUMP   = OPCODE_W'(0);
  localparam logic [OPCODE_W-1:0] OP_RTYPE  = OPCODE_W'(1);
  localparam logic [OPCODE_W-1:0] OP_LW     = OPCODE_W'(2);
  localparam logic [OPCODE_W-1:0] OP_SW     = OPCODE_W'(3);
  localparam logic [OPCODE_W-1:0] OP_BRANCH = OPCODE_W'(4);

  localparam logic [ALUOP_W-1:0] ALU_ADD   = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] ALU_SUB   = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] ALU_FUNCT = ALUOP_W'(2);
  localparam logic [ALUOP_W-1:0] ALU_PASS  = ALUOP_W'(3);

  state_t              state_q, state_d;
  logic [OPCODE_W-1:0] op_q, op_d;
  logic                illegal_q, illegal_d;
  logic [CNT_W-1:0]    retired_q;
  logic                retire;

  logic                pc_write_c, ir_write_c, reg_dst_c, alu_src_c, mem_to_reg_c;
  logic                reg_write_c, mem_read_c, mem_write_c, branch_c, jump_c;
  logic [ALUOP_W-1:0]  alu_op_c;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_FETCH;
      op_q      <= '0;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      illegal_q <= illegal_d;
      if (retire)
        retired_q <= retired_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d   = S_FETCH;
    op_d      = op_q;
    illegal_d = illegal_q;
    retire    = 1'b0;
    case (state_q)
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        state_d = S_EXEC;
        op_d    = opcode;
`ifdef HALT_OPCODE_EN
        if (opcode == {OPCODE_W{1'b1}}) begin
          state_d = S_HALT;
        end else if (opcode > OP_BRANCH) begin
          illegal_d = 1'b1;
          op_d      = OP_RTYPE;
        end
`else
        if (opcode > OP_BRANCH) begin
          illegal_d = 1'b1;
          op_d      = OP_RTYPE;
        end
`endif
      end
      S_EXEC: begin
        case (op_q)
          OP_RTYPE:     state_d = S_WB;
          OP_LW, OP_SW: state_d = S_MEM;
          default: begin
            state_d = S_FETCH;
            retire  = 1'b1;
          end
        endcase
      end
      S_MEM: begin
        if (!mem_ready) begin
          state_d = S_MEM;
        end else if (op_q == OP_LW) begin
          state_d = S_WB;
        end else begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end
      S_WB: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
`ifdef HALT_OPCODE_EN
      S_HALT:   state_d = S_HALT;
`endif
      default:  state_d = S_FETCH;
    endcase
  end

  always_comb begin
    pc_write_c   = 1'b0;
    ir_write_c   = 1'b0;
    reg_dst_c    = 1'b0;
    alu_src_c    = 1'b0;
    mem_to_reg_c = 1'b0;
    reg_write_c  = 1'b0;
    mem_read_c   = 1'b0;
    mem_write_c  = 1'b0;
    branch_c     = 1'b0;
    jump_c       = 1'b0;
    alu_op_c     = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        mem_read_c = 1'b1;
        ir_write_c = mem_ready;
        pc_write_c = mem_ready;
      end
      S_EXEC: begin
        case (op_q)
          OP_JUMP: begin
            jump_c     = 1'b1;
            pc_write_c = 1'b1;
            alu_op_c   = ALU_PASS;
          end
          OP_RTYPE: begin
            alu_op_c  = ALU_FUNCT;
            reg_dst_c = 1'b1;
          end
          OP_LW, OP_SW: alu_src_c = 1'b1;
          OP_BRANCH: begin
            branch_c = 1'b1;
            alu_op_c = ALU_SUB;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        alu_src_c   = 1'b1;
        mem_read_c  = (op_q == OP_LW);
        mem_write_c = (op_q == OP_SW);
      end
      S_WB: begin
        reg_write_c  = 1'b1;
        reg_dst_c    = (op_q != OP_LW);
        mem_to_reg_c = (op_q == OP_LW);
      end
      default: ;
    endcase
  end

  // Strobes are gated by reset_n directly so they drop the instant reset asserts.
  assign pc_write   = pc_write_c   & reset_n;
  assign ir_write   = ir_write_c   & reset_n;
  assign reg_dst    = reg_dst_c    & reset_n;
  assign alu_src    = alu_src_c    & reset_n;
  assign mem_to_reg = mem_to_reg_c & reset_n;
  assign reg_write  = reg_write_c  & reset_n;
  assign mem_read   = mem_read_c   & reset_n;
  assign mem_write  = mem_write_c  & reset_n;
  assign branch     = branch_c     & reset_n;
  assign jump       = jump_c       & reset_n;
  assign alu_op     = alu_op_c     & {ALUOP_W{reset_n}};

  assign state      = state_q;
  assign illegal_op = illegal_q;
  assign retired    = retired_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: walks each instruction class through its states,
// checks strobes, stalls, illegal flag, counter wrap (narrow counter instance) and async reset.
module tb_multicycle_control_unit;
  localparam int CW = 5;

  logic          clock = 1'b0;
  logic          reset_n;
  logic [3:0]    opcode;
  logic          mem_ready;
  logic          pc_write, ir_write, reg_dst, alu_src, mem_to_reg;
  logic          reg_write, mem_read, mem_write, branch, jump;
  logic [1:0]    alu_op;
  logic [2:0]    state;
  logic          illegal_op;
  logic [CW-1:0] retired;

  int vectors = 0;
  int miscompares = 0;

  multicycle_control_unit #(.OPCODE_W(4), .ALUOP_W(2), .CNT_W(CW)) dut (
    .clock(clock), .reset_n(reset_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .ir_write(ir_write), .reg_dst(reg_dst), .alu_src(alu_src),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .mem_read(mem_read),
    .mem_write(mem_write), .branch(branch), .jump(jump), .alu_op(alu_op),
    .state(state), .illegal_op(illegal_op), .retired(retired)
  );

  always #5 clock = ~clock;

  // strobe vector order: pc ir dst src m2r rw mr mw br jmp
  localparam logic [9:0] S_NONE    = 10'b0000000000;
  localparam logic [9:0] S_FETCH0  = 10'b0000001000;
  localparam logic [9:0] S_FETCH1  = 10'b1100001000;
  localparam logic [9:0] S_EX_R    = 10'b0010000000;
  localparam logic [9:0] S_WB_R    = 10'b0010010000;
  localparam logic [9:0] S_EX_MEM  = 10'b0001000000;
  localparam logic [9:0] S_MEM_LW  = 10'b0001001000;
  localparam logic [9:0] S_WB_LW   = 10'b0000110000;
  localparam logic [9:0] S_MEM_SW  = 10'b0001000100;
  localparam logic [9:0] S_EX_BR   = 10'b0000000010;
  localparam logic [9:0] S_EX_J    = 10'b1000000001;

  function automatic logic [9:0] strobes();
    return {pc_write, ir_write, reg_dst, alu_src, mem_to_reg,
            reg_write, mem_read, mem_write, branch, jump};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_cycle(input string tag, input logic [2:0] st, input logic [9:0] sv,
                           input logic [1:0] aop);
    chk({tag, ".state"}, 32'(state), 32'(st));
    chk({tag, ".strobes"}, 32'(strobes()), 32'(sv));
    chk({tag, ".alu_op"}, 32'(alu_op), 32'(aop));
  endtask

  // FETCH with ready=1 then DECODE, leaving the DUT at the start of EXEC
  task automatic fetch_decode(input logic [3:0] op);
    opcode    = op;
    mem_ready = 1'b1;
    #1;
    chk_cycle("fetch", 3'd0, S_FETCH1, 2'b00);
    tick();
    chk_cycle("decode", 3'd1, S_NONE, 2'b00);
    tick();
  endtask

  initial begin
    reset_n   = 1'b0;
    opcode    = 4'd0;
    mem_ready = 1'b0;
    #3;
    chk_cycle("reset", 3'd0, S_NONE, 2'b00);
    chk("reset.retired", 32'(retired), 32'd0);
    chk("reset.illegal", 32'(illegal_op), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    chk_cycle("fetch_wait", 3'd0, S_FETCH0, 2'b00);
    tick();
    chk_cycle("fetch_hold", 3'd0, S_FETCH0, 2'b00);

    // R-type
    fetch_decode(4'd1);
    chk_cycle("r.exec", 3'd2, S_EX_R, 2'b10);
    tick();
    chk_cycle("r.wb", 3'd4, S_WB_R, 2'b00);
    tick();
    chk("r.retired", 32'(retired), 32'd1);
    chk("r.back_fetch", 32'(state), 32'd0);

    // lw with two stall cycles in MEM
    fetch_decode(4'd2);
    mem_ready = 1'b0;
    chk_cycle("lw.exec", 3'd2, S_EX_MEM, 2'b00);
    tick();
    chk_cycle("lw.mem1", 3'd3, S_MEM_LW, 2'b00);
    tick();
    chk_cycle("lw.mem2", 3'd3, S_MEM_LW, 2'b00);
    tick();
    chk_cycle("lw.mem3", 3'd3, S_MEM_LW, 2'b00);
    chk("lw.no_early_retire", 32'(retired), 32'd1);
    mem_ready = 1'b1;
    tick();
    chk_cycle("lw.wb", 3'd4, S_WB_LW, 2'b00);
    tick();
    chk("lw.retired", 32'(retired), 32'd2);

    // sw then branch
    fetch_decode(4'd3);
    chk_cycle("sw.exec", 3'd2, S_EX_MEM, 2'b00);
    tick();
    chk_cycle("sw.mem", 3'd3, S_MEM_SW, 2'b00);
    tick();
    chk("sw.retired", 32'(retired), 32'd3);
    fetch_decode(4'd4);
    chk_cycle("br.exec", 3'd2, S_EX_BR, 2'b01);
    tick();
    chk("br.retired", 32'(retired), 32'd4);
    chk("br.state", 32'(state), 32'd0);

    // illegal opcode runs as R-type and the flag sticks
    fetch_decode(4'd7);
    chk("ill.flag", 32'(illegal_op), 32'd1);
    chk_cycle("ill.exec", 3'd2, S_EX_R, 2'b10);
    tick();
    chk_cycle("ill.wb", 3'd4, S_WB_R, 2'b00);
    tick();
    chk("ill.retired", 32'(retired), 32'd5);
    fetch_decode(4'd0);
    chk_cycle("j.exec", 3'd2, S_EX_J, 2'b11);
    tick();
    chk("j.retired", 32'(retired), 32'd6);
    chk("ill.sticky", 32'(illegal_op), 32'd1);

    // counter wrap on the narrow instance
    for (int i = 0; i < 25; i++) begin
      opcode = 4'd0;
      tick(); tick(); tick();
    end
    chk("wrap.max", 32'(retired), 32'd31);
    tick(); tick(); tick();
    chk("wrap.zero", 32'(retired), 32'd0);
    chk("wrap.state", 32'(state), 32'd0);

    // async reset mid-MEM of sw
    fetch_decode(4'd3);
    mem_ready = 1'b0;
    tick();
    chk_cycle("abort.mem", 3'd3, S_MEM_SW, 2'b00);
    #2;
    reset_n = 1'b0;
    #1;
    chk_cycle("abort.reset", 3'd0, S_NONE, 2'b00);
    chk("abort.retired", 32'(retired), 32'd0);
    chk("abort.illegal_cleared", 32'(illegal_op), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    fetch_decode(4'd1);
    tick();
    tick();
    chk("resume.retired", 32'(retired), 32'd1);

`ifdef HALT_OPCODE_EN
    fetch_decode(4'd15);
    for (int i = 0; i < 20; i++) begin
      chk_cycle("halt", 3'd5, S_NONE, 2'b00);
      tick();
    end
    chk("halt.illegal", 32'(illegal_op), 32'd0);
    chk("halt.retired", 32'(retired), 32'd1);
`else
    fetch_decode(4'd15);
    chk("ones.illegal", 32'(illegal_op), 32'd1);
    chk_cycle("ones.exec", 3'd2, S_EX_R, 2'b10);
    tick();
    tick();
    chk("ones.retired", 32'(retired), 32'd2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
